// File: rtl/pg_seg_adder_if.sv
// rtl/pg_seg_adder_if.sv - operand/result handshake bundle for pg_seg_adder
interface pg_seg_adder_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;

  modport master (
    output in_valid, a, b, c_in,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in,
    output in_ready, out_valid, sum, c_out
  );
endinterface

// File: rtl/pg_seg_adder.sv
// rtl/pg_seg_adder.sv - power-gated segmented ripple-carry adder with per-segment power sequencing
module pg_seg_adder #(
  parameter int SEG_W   = 16,
  parameter int N_SEG   = 4,
  parameter int PSW_DLY = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_SEG-2:0] i_seg_en,
  output logic [N_SEG-2:0] o_pse,
  output logic [N_SEG-2:0] o_iso_en,
  output logic [N_SEG-2:0] o_ret_en,
  pg_seg_adder_if.slave    bus
);
  localparam int W     = SEG_W * N_SEG;
  localparam int CNT_W = $clog2(PSW_DLY + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PUP,
    S_RESTORE,
    S_ON,
    S_ISO,
    S_SAVE
  } pwr_state_t;

  // w_on[0] is the always-on segment 0
  logic [N_SEG-1:0] w_on;
  logic [N_SEG-2:0] w_settled;
  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             r_out_valid;
  logic [W-1:0]     r_sum;
  logic             r_cout;

  assign w_on[0] = 1'b1;

  for (genvar g = 1; g < N_SEG; g++) begin : g_seg
    pwr_state_t       r_state;
    pwr_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // power state and settle counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= S_OFF;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // sequencing: requests are only looked at in the stable OFF/ON states
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      unique case (r_state)
        S_OFF:     if (i_seg_en[g-1]) w_state_nxt = S_PUP;
        S_PUP: begin
          if (r_cnt == CNT_W'(PSW_DLY - 1)) w_state_nxt = S_RESTORE;
          else                              w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
        S_RESTORE: w_state_nxt = S_ON;
        S_ON:      if (!i_seg_en[g-1]) w_state_nxt = S_ISO;
        S_ISO:     w_state_nxt = S_SAVE;
        S_SAVE:    w_state_nxt = S_OFF;
        default:   w_state_nxt = S_OFF;
      endcase
    end

    assign o_pse[g-1]     = (r_state != S_OFF);
    assign o_iso_en[g-1]  = (r_state != S_ON);
    assign o_ret_en[g-1]  = (r_state == S_OFF) || (r_state == S_PUP) || (r_state == S_SAVE);
    assign w_on[g]        = (r_state == S_ON);
    assign w_settled[g-1] = i_seg_en[g-1] ? (r_state == S_ON) : (r_state == S_OFF);
  end

  assign bus.in_ready = &w_settled;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // ripple through the contiguous powered prefix; segments past the first gap read as clamp 0
  always_comb begin
    logic             act;
    logic             carry;
    logic [SEG_W:0]   seg_add;
    w_sum   = '0;
    act     = 1'b1;
    carry   = bus.c_in;
    seg_add = '0;
    for (int s = 0; s < N_SEG; s++) begin
      act     = act && w_on[s];
      seg_add = {1'b0, bus.a[s*SEG_W +: SEG_W]} + {1'b0, bus.b[s*SEG_W +: SEG_W]}
              + (SEG_W+1)'(carry);
      if (act) begin
        w_sum[s*SEG_W +: SEG_W] = seg_add[SEG_W-1:0];
        carry                   = seg_add[SEG_W];
      end
    end
    w_cout = carry;
  end

  // result register: one-cycle valid pulse per accept, data held otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_cout;
endmodule

// File: tb/tb_pg_seg_adder.sv
// tb/tb_pg_seg_adder.sv - self-checking bench for pg_seg_adder
module tb_pg_seg_adder;
  localparam int SEG_W   = 16;
  localparam int N_SEG   = 4;
  localparam int PSW_DLY = 4;
  localparam int W       = SEG_W * N_SEG;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  typedef struct {
    logic [2:0]   en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] seg_en;
  logic [2:0] pse;
  logic [2:0] iso_en;
  logic [2:0] ret_en;
  int         total = 0;
  int         bad   = 0;
  exp_t       q[$];
  exp_t       m_e;

  pg_seg_adder_if #(.W(W)) bus ();

  pg_seg_adder #(.SEG_W(SEG_W), .N_SEG(N_SEG), .PSW_DLY(PSW_DLY)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_seg_en (seg_en),
    .o_pse    (pse),
    .o_iso_en (iso_en),
    .o_ret_en (ret_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every out_valid must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected out_valid=1 sum=%h want no result", bus.sum);
      end else begin
        m_e = q.pop_front();
        if (bus.sum !== m_e.sum || bus.c_out !== m_e.cout) begin
          bad++;
          $display("FAIL result got sum=%h c_out=%b want sum=%h c_out=%b",
                   bus.sum, bus.c_out, m_e.sum, m_e.cout);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // reference: add over the powered prefix as one wide number
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [2:0] en);
    int           m;
    logic [W:0]   full;
    logic [W-1:0] mask;
    exp_t         r;
    m = 1;
    for (int i = 0; i < 3; i++) if (en[i] && m == i + 1) m++;
    mask   = (m == 4) ? {W{1'b1}} : ((64'd1 << (m * SEG_W)) - 64'd1);
    full   = {1'b0, a & mask} + {1'b0, b & mask} + (W+1)'(cin);
    r.sum  = full[W-1:0] & mask;
    r.cout = full[m * SEG_W];
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready in_ready=0 after 50 cycles want 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input exp_t e);
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = cin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready) q.push_back(e);
    else begin
      bad++;
      $display("FAIL send_ready in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // {pse, iso_en, ret_en, in_ready} for segment 1, the other gated segments held OFF
  task automatic check_pwr(input string name, input logic [3:0] t);
    check(name, {54'd0, pse, iso_en, ret_en, bus.in_ready},
          {54'd0, 2'b00, t[3], 2'b11, t[2], 2'b11, t[1], t[0]});
  endtask

  vec_t       tab[7];
  logic [3:0] up_tab[6];
  logic [3:0] dn_tab[3];
  logic [3:0] tg_tab[9];
  exp_t       e;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;

  initial begin
    tab[0] = '{3'b000, 64'h0000_0000_0001_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    tab[1] = '{3'b001, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    tab[2] = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'h0000_0000_FFFF_FFFF, 1'b1};
    tab[3] = '{3'b111, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
               64'h1234_5678_9ABC_DF00, 1'b0};
    tab[4] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    tab[5] = '{3'b011, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0,
               64'h0000_0001_0001_0000, 1'b1};
    tab[6] = '{3'b110, 64'hFFFF_FFFF_FFFF_0001, 64'hFFFF_FFFF_FFFF_0002, 1'b1,
               64'h4, 1'b0};
    up_tab = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1001};
    dn_tab = '{4'b1100, 4'b1110, 4'b0111};
    tg_tab = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1000,
               4'b1100, 4'b1110, 4'b0111};

    seg_en       = 3'b000;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwr", {55'd0, pse, iso_en, ret_en}, {55'd0, 9'b000_111_111});
    check("reset_out", {bus.out_valid, bus.c_out, bus.sum[61:0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      seg_en = tab[i].en;
      wait_ready();
      send(tab[i].a, tab[i].b, tab[i].cin, '{tab[i].sum, tab[i].cout});
    end

    // power-up timing of segment 1
    seg_en = 3'b000;
    wait_ready();
    seg_en = 3'b001;
    @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check_pwr($sformatf("pwr_up_%0d", j), up_tab[j]);
    end

    // power-down timing; operand offered during the window must not be taken
    @(posedge clk);
    #1;
    seg_en       = 3'b000;
    bus.a        = 64'h5;
    bus.b        = 64'h6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_pwr($sformatf("pwr_dn_%0d", j), dn_tab[j]);
      check($sformatf("dn_no_valid_%0d", j), {63'd0, bus.out_valid}, 64'd0);
      if (j == 1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end
    end

    // request withdrawn during power-up: full up then full down
    @(posedge clk);
    #1;
    seg_en = 3'b001;
    @(posedge clk);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      check_pwr($sformatf("toggle_%0d", j), tg_tab[j]);
      if (j == 1) seg_en = 3'b000;
    end

    // asynchronous reset with a result pending
    @(posedge clk);
    #1;
    send(64'h1, 64'h1, 1'b0, '{64'h2, 1'b0});
    check("pend_result", {bus.out_valid, bus.sum[62:0]}, {1'b1, 63'h2});
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_clears_out", {bus.out_valid, bus.c_out, bus.sum[61:0]}, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // asynchronous reset during power-up
    seg_en = 3'b001;
    repeat (2) @(posedge clk);
    #2;
    check("mid_pup_pse", {61'd0, pse}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pup", {55'd0, pse, iso_en, ret_en}, {55'd0, 9'b000_111_111});
    seg_en = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {63'd0, bus.in_ready}, 64'd1);

    // back-to-back random operations against the reference
    seg_en = 3'b111;
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rc, seg_en);
      send(ra, rb, rc, e);
    end
    seg_en = 3'b011;
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rc, seg_en);
      send(ra, rb, rc, e);
    end
    seg_en = 3'b110;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      e  = model(ra, rb, rc, seg_en);
      send(ra, rb, rc, e);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
